// File: rtl/i2c_target_rx_if.sv
// i2c_target_rx_if
//   Bundles the I2C pins and the received-byte handshake of i2c_target_rx.
//   master : bus/fabric side (drives scl_in, sda_in and rx_ready)
//   slave  : the target (drives sda_oe, rx_data, rx_valid, rx_first, busy, rx_overflow)
//   scl_in, sda_in : raw, asynchronous bus levels
//   sda_oe         : 1 = pull SDA low (open-drain ACK)
//   rx_data/rx_valid/rx_ready/rx_first : 1-entry holding register handshake
//   busy           : START..STOP window
//   rx_overflow    : one-cycle pulse, byte dropped because holding register full
interface i2c_target_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       busy;
  logic       rx_overflow;

  modport master (
    output scl_in, sda_in, rx_ready,
    input  sda_oe, rx_data, rx_valid, rx_first, busy, rx_overflow
  );

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output sda_oe, rx_data, rx_valid, rx_first, busy, rx_overflow
  );
endinterface

// File: rtl/i2c_target_rx.sv
// i2c_target_rx
//   Write-only I2C target. Oversamples SCL/SDA on clk, detects START/STOP/
//   repeated START, ACKs address TGT_ADDR+W and every data byte that fits in
//   a 1-entry valid/ready holding register; NACKs everything else.
// Ports
//   clk   : system clock (SCL <= clk/8)
//   reset : synchronous, active-low
//   bus   : i2c_target_rx_if.slave (pins + rx handshake, see interface)
// Parameters
//   TGT_ADDR    : 7-bit address answered to
//   SYNC_STAGES : synchroniser depth (>= 2)
//   FILT_LEN    : glitch-filter stability length, only with the macro below
// Build option
//   I2C_TGT_GLITCH_FILTER_EN : adds a FILT_LEN-clk stability filter after the
//   synchronisers (adds FILT_LEN clks of latency, drops shorter pulses).
module i2c_target_rx #(
  parameter logic [6:0]  TGT_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_target_rx_if.slave        bus
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("i2c_target_rx: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_e;

  // Synchronisers, filter and edge history are not reset: they only track the
  // pins, so after a mid-frame reset they already hold true bus levels and
  // cannot manufacture a false START/STOP.
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_s, sda_s, scl_prev_q, sda_prev_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
  end

  always_ff @(posedge clk) begin
    scl_sync_q <= scl_sync_d;
    sda_sync_q <= sda_sync_d;
    scl_prev_q <= scl_s;
    sda_prev_q <= sda_s;
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  logic [1:0]    filt_raw, filt_q, filt_d;
  logic [CW-1:0] filt_cnt_q [2];
  logic [CW-1:0] filt_cnt_d [2];

  // Output follows the input only after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_raw   = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (filt_raw[i] == filt_q[i]) begin
        filt_cnt_d[i] = '0;
      end else if (filt_cnt_q[i] == CW'(FILT_LEN - 1)) begin
        filt_d[i]     = filt_raw[i];
        filt_cnt_d[i] = '0;
      end else begin
        filt_cnt_d[i] = filt_cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    filt_q     <= filt_d;
    filt_cnt_q <= filt_cnt_d;
  end

  assign scl_s = filt_q[1];
  assign sda_s = filt_q[0];
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic       first_pend_q, first_pend_d, ovf_q, ovf_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    rx_valid_d   = rx_valid_q;
    rx_first_d   = rx_first_q;
    first_pend_d = first_pend_q;
    ovf_d        = 1'b0;

    // Consumer handshake first, so a same-cycle load below can override it.
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d      = ADDR;
      bit_cnt_d    = '0;
      busy_d       = 1'b1;
      first_pend_d = 1'b1;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == TGT_ADDR && !shift_q[0]) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else if (!rx_valid_q || bus.rx_ready) begin
              rx_data_d    = shift_q;
              rx_valid_d   = 1'b1;
              rx_first_d   = first_pend_q;
              first_pend_d = 1'b0;
              sda_oe_d     = 1'b1;
              state_d      = DATA_ACK;
            end else begin
              ovf_d   = 1'b1;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      first_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      first_pend_q <= first_pend_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_first    = rx_first_q;
  assign bus.busy        = busy_q;
  assign bus.rx_overflow = ovf_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx
//   Directed bench for i2c_target_rx: a table of write frames with expected
//   ACK pattern and delivered bytes, plus hand sequences for repeated START,
//   overflow, same-cycle consume/load, mid-frame reset and (with
//   I2C_TGT_GLITCH_FILTER_EN) glitch rejection.
module tb_i2c_target_rx;
  localparam int unsigned Q = 8;  // clks per SCL quarter
`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int unsigned FL = 3;
`else
  localparam int unsigned FL = 0;
`endif
  localparam int unsigned LAT = 2 + FL;  // raw SCL fall -> last clk before load edge

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_target_rx_if bus ();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;  // open-drain wired-AND

  i2c_target_rx #(.TGT_ADDR(7'h50), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer-side monitor: bytes accepted, overflow cycles, ACK activity,
  // and any sda_oe movement while SCL is high.
  logic [8:0] acc_q[$];
  int   ovf_cycles = 0;
  int   oe_hi = 0;
  int   oe_bad = 0;
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) acc_q.push_back({bus.rx_first, bus.rx_data});
    if (bus.rx_overflow) ovf_cycles++;
    if (bus.sda_oe) oe_hi++;
    if (bus.sda_oe !== oe_prev && scl_m && reset) oe_bad++;
    oe_prev = bus.sda_oe;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // pulse: raise rx_ready for exactly the clk edge on which the byte loads.
  task automatic bit_out(input logic b, input bit pulse, output logic s);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    s = bus.sda_in;
    scl_m = 1'b0;
    if (pulse) begin
      tick(LAT);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
      tick(Q - LAT - 1);
    end else begin
      tick(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pulse, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], pulse && (i == 0), s);
    bit_out(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  typedef struct {
    logic [7:0] addr_byte;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [2:0] exp_ack;   // {byte1, byte0, address}
    int         exp_nacc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [2:0] acks;
    logic       a;
    logic [8:0] got;
    logic [8:0] exp;

    vecs[0] = '{8'hA0, 1, 8'hAA, 8'h00, 3'b011, 1};  // 0x50+W, 0xAA
    vecs[1] = '{8'hA2, 1, 8'h5A, 8'h00, 3'b000, 0};  // 0x51+W
    vecs[2] = '{8'hA1, 1, 8'h77, 8'h00, 3'b000, 0};  // 0x50+R
    vecs[3] = '{8'hA0, 2, 8'h01, 8'h80, 3'b111, 2};
    vecs[4] = '{8'h54, 2, 8'hFF, 8'h00, 3'b000, 0};  // 0x2A+W
    vecs[5] = '{8'hA0, 2, 8'hFF, 8'h00, 3'b111, 2};
    vecs[6] = '{8'hE0, 1, 8'hC3, 8'h00, 3'b000, 0};  // 0x70+W

    bus.rx_ready = 1'b0;
    reset = 1'b0;
    tick(10);
    check("rst_sda_oe",   32'(bus.sda_oe),      32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid),    32'd0);
    check("rst_rx_data",  32'(bus.rx_data),     32'd0);
    check("rst_rx_first", 32'(bus.rx_first),    32'd0);
    check("rst_busy",     32'(bus.busy),        32'd0);
    check("rst_overflow", 32'(bus.rx_overflow), 32'd0);
    reset = 1'b1;
    tick(10);

    for (int v = 0; v < 7; v++) begin
      bus.rx_ready = 1'b1;
      acc_q.delete();
      ovf_cycles = 0;
      oe_hi = 0;
      acks = '0;
      i2c_start();
      check($sformatf("v%0d_busy_start", v), 32'(bus.busy), 32'd1);
      send_byte(vecs[v].addr_byte, 1'b0, a); acks[0] = a;
      if (vecs[v].nbytes >= 1) begin send_byte(vecs[v].b0, 1'b0, a); acks[1] = a; end
      if (vecs[v].nbytes >= 2) begin send_byte(vecs[v].b1, 1'b0, a); acks[2] = a; end
      i2c_stop();
      tick(4);
      check($sformatf("v%0d_acks", v), 32'(acks), 32'(vecs[v].exp_ack));
      check($sformatf("v%0d_nbytes", v), 32'(acc_q.size()), 32'(vecs[v].exp_nacc));
      for (int k = 0; k < vecs[v].exp_nacc; k++) begin
        got = (k < acc_q.size()) ? acc_q[k] : 9'h1FF;
        exp = {(k == 0), (k == 0) ? vecs[v].b0 : vecs[v].b1};
        check($sformatf("v%0d_byte%0d", v, k), 32'(got), 32'(exp));
      end
      check($sformatf("v%0d_ovf", v), 32'(ovf_cycles), 32'd0);
      check($sformatf("v%0d_ack_driven", v), 32'(oe_hi != 0), 32'(vecs[v].exp_ack != 0));
      check($sformatf("v%0d_busy_end", v), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_valid_end", v), 32'(bus.rx_valid), 32'd0);
    end

    // Read address NACKed, then repeated START with a write.
    acc_q.delete();
    bus.rx_ready = 1'b1;
    i2c_start();
    send_byte(8'hA1, 1'b0, a); check("rs_read_nack", 32'(a), 32'd0);
    send_byte(8'h55, 1'b0, a); check("rs_ignored",   32'(a), 32'd0);
    i2c_start();
    check("rs_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hA0, 1'b0, a); check("rs_addr_ack", 32'(a), 32'd1);
    send_byte(8'h3C, 1'b0, a); check("rs_data_ack", 32'(a), 32'd1);
    i2c_stop();
    tick(4);
    check("rs_nbytes", 32'(acc_q.size()), 32'd1);
    got = (acc_q.size() > 0) ? acc_q[0] : 9'h1FF;
    check("rs_byte", 32'(got), 32'h13C);

    // Overflow: consumer stalled, second byte dropped.
    acc_q.delete();
    ovf_cycles = 0;
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'hA0, 1'b0, a); check("ov_addr_ack", 32'(a), 32'd1);
    send_byte(8'h11, 1'b0, a); check("ov_b0_ack",   32'(a), 32'd1);
    send_byte(8'h22, 1'b0, a); check("ov_b1_nack",  32'(a), 32'd0);
    i2c_stop();
    tick(4);
    check("ov_pulses",   32'(ovf_cycles),   32'd1);
    check("ov_valid",    32'(bus.rx_valid), 32'd1);
    check("ov_data",     32'(bus.rx_data),  32'h11);
    check("ov_first",    32'(bus.rx_first), 32'd1);
    check("ov_busy_end", 32'(bus.busy),     32'd0);

    // Drain, then consume the held byte on the exact load edge of the next.
    bus.rx_ready = 1'b1;
    tick(2);
    bus.rx_ready = 1'b0;
    acc_q.delete();
    ovf_cycles = 0;
    i2c_start();
    send_byte(8'hA0, 1'b0, a); check("sc_addr_ack", 32'(a), 32'd1);
    send_byte(8'h11, 1'b0, a); check("sc_b0_ack",   32'(a), 32'd1);
    send_byte(8'h22, 1'b1, a); check("sc_b1_ack",   32'(a), 32'd1);
    i2c_stop();
    tick(4);
    check("sc_nbytes", 32'(acc_q.size()), 32'd1);
    got = (acc_q.size() > 0) ? acc_q[0] : 9'h1FF;
    check("sc_consumed", 32'(got),          32'h111);
    check("sc_data",     32'(bus.rx_data),  32'h22);
    check("sc_first",    32'(bus.rx_first), 32'd0);
    check("sc_valid",    32'(bus.rx_valid), 32'd1);
    check("sc_ovf",      32'(ovf_cycles),   32'd0);

    // Reset while data bit 4 (SCL high) of 0xC3 is on the wire; 0x22 still held.
    i2c_start();
    send_byte(8'hA0, 1'b0, a); check("mr_addr_ack", 32'(a), 32'd1);
    bit_out(1'b1, 1'b0, a);
    bit_out(1'b1, 1'b0, a);
    bit_out(1'b0, 1'b0, a);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q / 2);
    check("mr_pre_busy",  32'(bus.busy),     32'd1);
    check("mr_pre_valid", 32'(bus.rx_valid), 32'd1);
    reset = 1'b0;
    tick(1);
    check("mr_sda_oe",   32'(bus.sda_oe),      32'd0);
    check("mr_rx_valid", 32'(bus.rx_valid),    32'd0);
    check("mr_rx_data",  32'(bus.rx_data),     32'd0);
    check("mr_rx_first", 32'(bus.rx_first),    32'd0);
    check("mr_busy",     32'(bus.busy),        32'd0);
    check("mr_overflow", 32'(bus.rx_overflow), 32'd0);
    reset = 1'b1;
    bus.rx_ready = 1'b1;
    acc_q.delete();
    tick(Q / 2 - 1);
    scl_m = 1'b0; tick(Q);
    bit_out(1'b0, 1'b0, a);
    bit_out(1'b0, 1'b0, a);
    bit_out(1'b1, 1'b0, a);
    bit_out(1'b1, 1'b0, a);
    bit_out(1'b1, 1'b0, a);
    check("mr_rest_nack", 32'(a), 32'd1);  // SDA left high: no ACK
    check("mr_busy_after", 32'(bus.busy), 32'd0);
    i2c_stop();
    tick(4);
    check("mr_nbytes_ignored", 32'(acc_q.size()), 32'd0);
    i2c_start();
    send_byte(8'hA0, 1'b0, a); check("mr2_addr_ack", 32'(a), 32'd1);
    send_byte(8'h96, 1'b0, a); check("mr2_data_ack", 32'(a), 32'd1);
    i2c_stop();
    tick(4);
    check("mr2_nbytes", 32'(acc_q.size()), 32'd1);
    got = (acc_q.size() > 0) ? acc_q[0] : 9'h1FF;
    check("mr2_byte", 32'(got), 32'h196);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    // 2-clk SDA low glitch while SCL idles high must not look like START.
    sda_m = 1'b0; tick(2);
    sda_m = 1'b1; tick(20);
    check("gl_busy", 32'(bus.busy), 32'd0);
`endif

    check("sda_oe_stable_scl_high", 32'(oe_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
